draw_scheduler: RTL
===================

// Module: draw_scheduler
// PURPOSE
//  Shares the single sprite drawer (item/erase/position inputs) between NUM_REQ game FSMs.
//  Examples are garbage draw, press erase/draw and garbage erase.
//  Each requester posts a command; a round-robin arbiter grants one at a time.
//  For the granted command it drives the drawer, pulses go, and holds for the fixed item draw time.
//  It then returns a one-cycle ack. This removes the per-FSM delay counters and the multi-driver conflict.
// PARAMETERS
//  NUM_REQ       4     number of requesters (ID_W = 2 bits for id)
//  GARB_CYCLES   401   drawer busy time for item=0 (garbage sprite)
//  PRESS_CYCLES  2401  drawer busy time for item=1 (press sprite)
//  CNT_W         12    width of busy counter; must hold PRESS_CYCLES
// PORTS
//  clock       in   1          system clock (CLOCK_50)
//  reset       in   1          asynchronous, active-high reset
//  req         in   NUM_REQ    req[i]=1: requester i has a command pending (level, held until ack[i])
//  req_item    in   NUM_REQ    per-requester item select (0 garbage, 1 press)
//  req_erase   in   NUM_REQ    per-requester erase flag (1 erase, 0 draw)
//  req_pos     in   3*NUM_REQ  per-requester position, slice [3*i+2:3*i]
//  ack         out  NUM_REQ    one-cycle pulse when requester i's command has completed
//  busy        out  1          1 whenever state != IDLE
//  grant_id    out  2          index of current/last granted requester
//  draw_item   out  1          to drawer item input
//  draw_erase  out  1          to drawer erase input
//  draw_pos    out  3          to drawer position input
//  draw_go     out  1          one-cycle start strobe to drawer
// BEHAVIOUR
//  Reset: state=IDLE; ack=0, busy=0, draw_go=0, draw_item=0, draw_erase=0, draw_pos=0, grant_id=0.
//  Reset also sets rr_ptr=NUM_REQ-1, so requester 0 has first priority.
//  Reset mid-operation aborts the command: no ack is issued and draw_go drops immediately.
//  All outputs are registered.
//  FSM states:
//   IDLE:  if |req, pick the first i with req[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
//          Latch req_item/req_erase/req_pos[i] into draw_*, set grant_id=i, then go to ISSUE.
//          If no req, stay in IDLE.
//   ISSUE: draw_go=1 for exactly this cycle.
//          Load cnt = (draw_item ? PRESS_CYCLES : GARB_CYCLES) - 1, then go to WAIT.
//   WAIT:  if cnt==0, go to ACK; otherwise cnt = cnt-1.
//          draw_* stay constant throughout WAIT.
//   ACK:   ack[grant_id]=1 for this cycle only, set rr_ptr=grant_id, then go to IDLE.
//  Timing: req sampled high at the end of an IDLE cycle t gives draw_go high in cycle t+1.
//   ack is high in cycle t+2+N, where N = GARB_CYCLES or PRESS_CYCLES.
//   Back-to-back grants are separated by one IDLE cycle.
//  Command values are latched at grant.
//   Changes to req_* or deassertion of req[i] after grant are ignored; the command still completes and acks.
//  Requester contract: drop req[i] on the clock edge at which it samples ack[i]=1.
//   The ack cycle is followed by IDLE, so the completed command is never re-granted.
//  Non-requesting and non-granted req bits have no effect outside IDLE.
//  Simultaneous requests: round-robin order only; no starvation.
//   Each requester waits at most NUM_REQ-1 other commands.
//  draw_pos is passed through unmodified (0..5); range checking is left to the drawer.
//  cnt never wraps: it is loaded only in ISSUE and stops at 0.
// TESTING
//  1. After reset, req=4'b0001, item=0, erase=0, pos=2 -> draw_go in the 2nd cycle with draw_pos=2.
//     ack[0] pulses 403 cycles after the req sample; busy=1 throughout.
//  2. req=4'b0010, item=1, erase=1, pos=5 -> draw_erase=1, draw_item=1.
//     ack[1] pulses 2403 cycles after the req sample.
//  3. req=4'b1111 held, each requester drops its req on its ack -> grant order 0,1,2,3.
//     Exactly one ack per requester; never two acks high in the same cycle.
//  4. Grant to 0, then req=4'b0101 held -> next grant is 2, not 0 (round-robin).
//  5. Change req_pos[2:0] from 2 to 4 during WAIT -> draw_pos stays 2 until ack.
//  6. Assert reset 100 cycles into WAIT -> no ack, all outputs 0 next cycle.
//     After release, a new req is granted normally starting from requester 0.

Source files
------------

// File: rtl/draw_scheduler_if.sv
// Requester/drawer bundle for draw_scheduler: per-requester command bus,
// ack/status back to the FSMs, and the shared drawer controls.
interface draw_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_item;
  logic [NUM_REQ-1:0]   req_erase;
  logic [3*NUM_REQ-1:0] req_pos;
  logic [NUM_REQ-1:0]   ack;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;
  logic                 draw_item;
  logic                 draw_erase;
  logic [2:0]           draw_pos;
  logic                 draw_go;

  modport master (
    output req, req_item, req_erase, req_pos,
    input  ack, busy, grant_id, draw_item, draw_erase, draw_pos, draw_go
  );

  modport slave (
    input  req, req_item, req_erase, req_pos,
    output ack, busy, grant_id, draw_item, draw_erase, draw_pos, draw_go
  );
endinterface

// File: rtl/draw_scheduler.sv
// Round-robin sharing of the single sprite drawer between NUM_REQ game FSMs:
// grant, strobe go, hold for the fixed item draw time, then pulse ack.
module draw_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned GARB_CYCLES  = 401,
  parameter int unsigned PRESS_CYCLES = 2401,
  parameter int unsigned CNT_W        = 12
) (
  input logic             clock,
  input logic             reset,
  draw_scheduler_if.slave bus
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] GARB_LOAD  = CNT_W'(GARB_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    grant_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               busy_q;
  logic               go_q;
  logic               item_q;
  logic               erase_q;
  logic [2:0]         pos_q;

  logic [ID_W-1:0]    grant_d;
  logic               grant_vld_d;
  int unsigned        scan_idx;
  logic               sel_item;
  logic               sel_erase;
  logic [2:0]         sel_pos;

  // First pending requester after the last one served, wrapping modulo NUM_REQ.
  always_comb begin
    grant_d     = '0;
    grant_vld_d = 1'b0;
    scan_idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_vld_d && 1'(bus.req >> scan_idx)) begin
        grant_vld_d = 1'b1;
        grant_d     = ID_W'(scan_idx);
      end
    end
  end

  always_comb begin
    sel_item  = 1'(bus.req_item >> grant_d);
    sel_erase = 1'(bus.req_erase >> grant_d);
    sel_pos   = 3'(bus.req_pos >> (3 * grant_d));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      grant_q  <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      go_q     <= 1'b0;
      item_q   <= 1'b0;
      erase_q  <= 1'b0;
      pos_q    <= '0;
    end else begin
      ack_q <= '0;
      go_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (grant_vld_d) begin
            grant_q <= grant_d;
            item_q  <= sel_item;
            erase_q <= sel_erase;
            pos_q   <= sel_pos;
            go_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= item_q ? PRESS_LOAD : GARB_LOAD;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // ack is registered, so it is raised on the edge entering ACK
          if (cnt_q == '0) begin
            ack_q   <= NUM_REQ'(1) << grant_q;
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_ACK: begin
          rr_ptr_q <= grant_q;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ack        = ack_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = grant_q;
  assign bus.draw_item  = item_q;
  assign bus.draw_erase = erase_q;
  assign bus.draw_pos   = pos_q;
  assign bus.draw_go    = go_q;
endmodule
